snitch_icache_l0_refill_arb: RTL and testbench
==============================================

Name: snitch_icache_l0_refill_arb

Overview:
Shares the single L1 refill request/response channel among NR_PORTS private L0 line caches.
- Arbitrates demand refills ahead of prefetches, with round-robin fairness inside each class.
- Locks the grant until handshake and limits outstanding refills per port.
- Routes each response back to the issuing L0 using the port index carried in the request ID.
- Sits between the per-core L0 instances and the shared L1 lookup.

Parameters:
NR_PORTS, 4, number of L0 requesters (>=1)
FETCH_AW, 32, refill address width
LINE_WIDTH, 128, refill data width
MAX_OUTSTANDING, 2, maximum un-responded refills per port (>=1)
PORT_IDW, max(1,$clog2(NR_PORTS)), derived: port index width
ID_W, PORT_IDW+1, derived: upstream request/response ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
in_req_addr_i  in  NR_PORTS x FETCH_AW  per-port line address
in_req_id_i  in  NR_PORTS x ID_W  per-port ID; only bit0 (is_prefetch) is used
in_req_valid_i  in  NR_PORTS  per-port request valid
in_req_ready_o  out  NR_PORTS  per-port request ready
in_rsp_data_o  out  NR_PORTS x LINE_WIDTH  per-port response data (broadcast)
in_rsp_error_o  out  NR_PORTS  per-port response error (broadcast)
in_rsp_id_o  out  NR_PORTS x ID_W  per-port response ID (broadcast, unmodified)
in_rsp_valid_o  out  NR_PORTS  per-port response valid
in_rsp_ready_i  in  NR_PORTS  per-port response ready
out_req_addr_o  out  FETCH_AW  upstream address
out_req_id_o  out  ID_W  {granted port index, is_prefetch}
out_req_valid_o  out  1  upstream request valid
out_req_ready_i  in  1  upstream request ready
out_rsp_data_i  in  LINE_WIDTH  upstream response data
out_rsp_error_i  in  1  upstream response error
out_rsp_id_i  in  ID_W  upstream response ID
out_rsp_valid_i  in  1  upstream response valid
out_rsp_ready_o  out  1  upstream response ready
bad_id_o  out  1  sticky flag: a response arrived with port index >= NR_PORTS

Behaviour:
- Reset values:
  - rr_ptr_q=0, lock_q=0, all outstanding counters=0, bad_id_o=0.
  - All valid/ready outputs low until inputs become valid.
- Eligibility: port i is eligible when in_req_valid_i[i] and cnt_q[i] < MAX_OUTSTANDING.
  - A port at the limit gets in_req_ready_o[i]=0.
- Class priority: if any eligible port has id bit0=0 (demand), only demand ports compete; otherwise prefetch ports compete.
- Round-robin within the class:
  - Start the search at rr_ptr_q and pick the first eligible index, wrapping mod NR_PORTS.
  - On an upstream handshake, rr_ptr_q <= granted+1 (wraps to 0 at NR_PORTS-1).
- Grant lock:
  - If out_req_valid_o && !out_req_ready_i, latch lock_q=1 and locked_idx_q.
  - Next cycle the same port is granted regardless of priority or eligibility changes, so address and ID stay stable (L0 holds them).
  - lock_q clears on handshake.
  - A locked port that drops valid is an L0 protocol violation; assert it.
- Datapath: out_req_valid_o = any eligible (or lock_q); addr = addr of granted port; out_req_id_o = {idx, bit0}.
  - in_req_ready_o[g] = out_req_ready_i for the granted port only; 0 for all others.
  - Combinational request path, zero added latency.
- Responses:
  - p = out_rsp_id_i[ID_W-1:1]; in_rsp_valid_o[p] = out_rsp_valid_i; out_rsp_ready_o = in_rsp_ready_i[p].
  - Data, error and ID go to all ports.
  - If p >= NR_PORTS: out_rsp_ready_o=1, the response is dropped, and bad_id_o is set (sticky until reset).
- Counters:
  - cnt[i] +1 on a request handshake for i; -1 on a response handshake for i.
  - Both in the same cycle: cnt unchanged.
  - Counter width is $clog2(MAX_OUTSTANDING+1).
  - Assert no underflow and no overflow.
- Response ordering is not assumed; counters only bound occupancy.
- Reset mid-transaction clears lock, counters and pointer; in-flight upstream responses after reset are the system's responsibility.

Decomposition:
- snitch_icache_pkg gains a refill_req_t {addr, id} struct and a function that derives ID_W from NR_PORTS.
- One natural sub-module: snitch_icache_rr_pick (masked round-robin first-one search, NR_PORTS wide, built on lzc), instantiated for the demand mask and the prefetch mask.

Test Plan:
1. Reset, then port 2 requests demand addr 0x1000 with id bit0=0, ready=1 -> same cycle out_req_addr_o=0x1000, out_req_id_o={2,0}, in_req_ready_o=4'b0100; rr_ptr becomes 3.
2. Port 0 prefetch and port 3 demand in the same cycle -> port 3 is granted first; port 0 is granted the next cycle with id={0,1}.
3. All 4 ports issue demand continuously with ready=1 -> grants follow 0,1,2,3,0; no port waits more than 3 grants.
4. Port 1 granted with ready=0 for 3 cycles while port 0 raises demand -> out_req stays {port1 addr, id={1,x}} until ready, then port 0 is granted.
5. Port 0 issues 2 requests with no responses (MAX_OUTSTANDING=2) -> third request sees in_req_ready_o[0]=0; a response with id={0,0} frees a slot and the third request is granted the following cycle.
6. With NR_PORTS=3, a response with id={3,0} -> out_rsp_ready_o=1, no in_rsp_valid_o asserted, bad_id_o=1 and held; a response with id={1,1} is delivered only to port 1.

Source files
------------

// File: rtl/snitch_icache_l0_refill_arb_pkg.sv
// Shared types and width helpers for the L0 refill arbiter.
package snitch_icache_l0_refill_arb_pkg;

    function automatic int unsigned port_idw(input int unsigned nr_ports);
        return (nr_ports > 1) ? int'($clog2(nr_ports)) : 1;
    endfunction

    // Upstream ID is {port index, is_prefetch}.
    function automatic int unsigned id_width(input int unsigned nr_ports);
        return port_idw(nr_ports) + 1;
    endfunction

    localparam int unsigned RefillAw  = 32;
    localparam int unsigned RefillIdW = 3;

    typedef struct packed {
        logic [RefillAw-1:0]  addr;
        logic [RefillIdW-1:0] id;
    } refill_req_t;

    typedef enum logic [0:0] {StIdle, StLocked} lock_state_e;

endpackage

// File: rtl/snitch_icache_l0_refill_arb_if.sv
// Refill channel bundle: NR_PORTS L0-facing channels plus the single L1-facing channel.
interface snitch_icache_l0_refill_arb_if
    import snitch_icache_l0_refill_arb_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 4,
    parameter int unsigned FETCH_AW   = 32,
    parameter int unsigned LINE_WIDTH = 128
);
    localparam int unsigned ID_W = id_width(NR_PORTS);

    logic [NR_PORTS-1:0][FETCH_AW-1:0]   in_req_addr;
    logic [NR_PORTS-1:0][ID_W-1:0]       in_req_id;
    logic [NR_PORTS-1:0]                 in_req_valid;
    logic [NR_PORTS-1:0]                 in_req_ready;
    logic [NR_PORTS-1:0][LINE_WIDTH-1:0] in_rsp_data;
    logic [NR_PORTS-1:0]                 in_rsp_error;
    logic [NR_PORTS-1:0][ID_W-1:0]       in_rsp_id;
    logic [NR_PORTS-1:0]                 in_rsp_valid;
    logic [NR_PORTS-1:0]                 in_rsp_ready;
    logic [FETCH_AW-1:0]                 out_req_addr;
    logic [ID_W-1:0]                     out_req_id;
    logic                                out_req_valid;
    logic                                out_req_ready;
    logic [LINE_WIDTH-1:0]               out_rsp_data;
    logic                                out_rsp_error;
    logic [ID_W-1:0]                     out_rsp_id;
    logic                                out_rsp_valid;
    logic                                out_rsp_ready;

    // master: the arbiter, which owns the upstream request; slave: L0s and L1 around it.
    modport master (
        input  in_req_addr, in_req_id, in_req_valid, in_rsp_ready,
        input  out_req_ready, out_rsp_data, out_rsp_error, out_rsp_id, out_rsp_valid,
        output in_req_ready, in_rsp_data, in_rsp_error, in_rsp_id, in_rsp_valid,
        output out_req_addr, out_req_id, out_req_valid, out_rsp_ready
    );

    modport slave (
        output in_req_addr, in_req_id, in_req_valid, in_rsp_ready,
        output out_req_ready, out_rsp_data, out_rsp_error, out_rsp_id, out_rsp_valid,
        input  in_req_ready, in_rsp_data, in_rsp_error, in_rsp_id, in_rsp_valid,
        input  out_req_addr, out_req_id, out_req_valid, out_rsp_ready
    );

endinterface

// File: rtl/snitch_icache_rr_pick.sv
// Round-robin first-one search: lowest set bit at or above ptr_i, else lowest set bit overall.
module snitch_icache_rr_pick #(
    parameter int unsigned NR_PORTS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    logic [NR_PORTS-1:0] masked;

    function automatic logic [IDX_W-1:0] first_one(input logic [NR_PORTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        masked = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            masked[i] = req_i[i] && (IDX_W'(i) >= ptr_i);
        end
    end

    assign idx_o   = (|masked) ? first_one(masked) : first_one(req_i);
    assign valid_o = |req_i;

endmodule

// File: rtl/snitch_icache_l0_refill_arb.sv
// Shares the L1 refill channel among NR_PORTS L0 caches: demand-over-prefetch round-robin,
// grant lock until handshake, per-port outstanding limit and ID-based response routing.
module snitch_icache_l0_refill_arb
    import snitch_icache_l0_refill_arb_pkg::*;
#(
    parameter int unsigned NR_PORTS        = 4,
    parameter int unsigned FETCH_AW        = 32,
    parameter int unsigned LINE_WIDTH      = 128,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    snitch_icache_l0_refill_arb_if.master bus,
    output logic                          bad_id_o
);

    localparam int unsigned PORT_IDW = port_idw(NR_PORTS);
    localparam int unsigned ID_W     = id_width(NR_PORTS);
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);

    lock_state_e state_q, state_d;
    logic [PORT_IDW-1:0] rr_ptr_q, rr_ptr_d, locked_idx_q, locked_idx_d;
    logic [PORT_IDW-1:0] dem_idx, pf_idx, gnt_idx;
    logic dem_valid, pf_valid, req_hs;
    logic [NR_PORTS-1:0] eligible, demand_mask, prefetch_mask;
    logic [NR_PORTS-1:0] req_hs_vec, rsp_hs_vec;
    logic [NR_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [FETCH_AW-1:0] gnt_addr;
    logic [LINE_WIDTH-1:0] rsp_data;
    logic [PORT_IDW-1:0] rsp_port;
    logic rsp_bad, bad_id_q, bad_id_d;

    always_comb begin
        eligible      = '0;
        demand_mask   = '0;
        prefetch_mask = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            eligible[i]      = bus.in_req_valid[i] && (cnt_q[i] < MaxOut);
            demand_mask[i]   = eligible[i] && !bus.in_req_id[i][0];
            prefetch_mask[i] = eligible[i] && bus.in_req_id[i][0];
        end
    end

    snitch_icache_rr_pick #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (PORT_IDW)
    ) i_pick_demand (
        .req_i   (demand_mask),
        .ptr_i   (rr_ptr_q),
        .idx_o   (dem_idx),
        .valid_o (dem_valid)
    );

    snitch_icache_rr_pick #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (PORT_IDW)
    ) i_pick_prefetch (
        .req_i   (prefetch_mask),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pf_idx),
        .valid_o (pf_valid)
    );

    // While locked the L0 holds addr/ID stable, so the old grant is simply replayed.
    assign gnt_idx          = (state_q == StLocked) ? locked_idx_q : (dem_valid ? dem_idx : pf_idx);
    assign bus.out_req_valid = (state_q == StLocked) || dem_valid || pf_valid;
    assign gnt_addr         = bus.in_req_addr[gnt_idx];
    assign bus.out_req_addr = gnt_addr;
    assign bus.out_req_id   = {gnt_idx, bus.in_req_id[gnt_idx][0]};
    assign req_hs           = bus.out_req_valid && bus.out_req_ready;

    always_comb begin
        bus.in_req_ready = '0;
        if (bus.out_req_valid) bus.in_req_ready[gnt_idx] = bus.out_req_ready;
    end

    always_comb begin
        state_d      = state_q;
        locked_idx_d = locked_idx_q;
        rr_ptr_d     = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (bus.out_req_valid && !bus.out_req_ready) begin
                    state_d      = StLocked;
                    locked_idx_d = gnt_idx;
                end
            end
            StLocked: begin
                if (bus.out_req_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (req_hs) begin
            rr_ptr_d = (gnt_idx == PORT_IDW'(NR_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Responses: route by the port index in the ID; out-of-range indices are swallowed.
    assign rsp_port = bus.out_rsp_id[ID_W-1:1];
    assign rsp_bad  = {1'b0, rsp_port} >= (PORT_IDW + 1)'(NR_PORTS);
    assign rsp_data = bus.out_rsp_data;

    always_comb begin
        bus.out_rsp_ready = rsp_bad;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            bus.in_rsp_data[i]  = rsp_data;
            bus.in_rsp_error[i] = bus.out_rsp_error;
            bus.in_rsp_id[i]    = bus.out_rsp_id;
            bus.in_rsp_valid[i] = bus.out_rsp_valid && !rsp_bad && (rsp_port == PORT_IDW'(i));
            if (rsp_port == PORT_IDW'(i)) begin
                bus.out_rsp_ready = bus.out_rsp_ready | bus.in_rsp_ready[i];
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        req_hs_vec = '0;
        rsp_hs_vec = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            req_hs_vec[i] = bus.in_req_valid[i] && bus.in_req_ready[i];
            rsp_hs_vec[i] = bus.in_rsp_valid[i] && bus.in_rsp_ready[i];
            if (req_hs_vec[i] && !rsp_hs_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (rsp_hs_vec[i] && !req_hs_vec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    assign bad_id_d = bad_id_q || (bus.out_rsp_valid && rsp_bad);
    assign bad_id_o = bad_id_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            locked_idx_q <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            bad_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_idx_q <= locked_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            bad_id_q     <= bad_id_d;
        end
    end

    // L0 must hold its request until the locked grant completes.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StLocked) |-> bus.in_req_valid[locked_idx_q]);

    for (genvar i = 0; i < NR_PORTS; i++) begin : gen_cnt_chk
        a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (cnt_q[i] == MaxOut) |-> !(req_hs_vec[i] && !rsp_hs_vec[i]));
        a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (cnt_q[i] == '0) |-> !(rsp_hs_vec[i] && !req_hs_vec[i]));
    end

endmodule

// File: tb/tb_snitch_icache_l0_refill_arb.sv
// Directed bench: vector table on a 4-port arbiter, hand sequences on a 3-port one.
module tb_snitch_icache_l0_refill_arb;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic bad4, bad3;
    int   n_vec  = 0;
    int   n_fail = 0;
    logic [31:0]  port_addr [4];
    logic [127:0] rsp_line;

    always #5 clk_i = ~clk_i;

    snitch_icache_l0_refill_arb_if #(.NR_PORTS(4), .FETCH_AW(32), .LINE_WIDTH(128)) bus4 ();
    snitch_icache_l0_refill_arb_if #(.NR_PORTS(3), .FETCH_AW(32), .LINE_WIDTH(128)) bus3 ();

    snitch_icache_l0_refill_arb #(
        .NR_PORTS        (4),
        .FETCH_AW        (32),
        .LINE_WIDTH      (128),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .bus      (bus4),
        .bad_id_o (bad4)
    );

    snitch_icache_l0_refill_arb #(
        .NR_PORTS        (3),
        .FETCH_AW        (32),
        .LINE_WIDTH      (128),
        .MAX_OUTSTANDING (2)
    ) dut3 (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .bus      (bus3),
        .bad_id_o (bad3)
    );

    typedef struct {
        bit         rst;
        logic [3:0] vld;
        logic [3:0] pf;
        logic       ordy;
        logic       rsp_v;
        logic [2:0] rsp_id;
        logic       exp_v;
        logic [2:0] exp_id;
        logic [3:0] exp_rdy;
        logic [3:0] exp_rspv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [3:0] vld, input logic [3:0] pf,
                       input logic ordy, input logic rsp_v, input logic [2:0] rsp_id,
                       input logic exp_v, input logic [2:0] exp_id,
                       input logic [3:0] exp_rdy, input logic [3:0] exp_rspv);
        vec_t v;
        v = '{rst, vld, pf, ordy, rsp_v, rsp_id, exp_v, exp_id, exp_rdy, exp_rspv};
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic ok;
        logic [31:0] exp_addr;

        port_addr[0] = 32'h0000_0100;
        port_addr[1] = 32'h0000_0200;
        port_addr[2] = 32'h0000_1000;
        port_addr[3] = 32'h0000_3000;
        rsp_line     = 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0BAD_F00D;

        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus4.in_req_addr[i] = port_addr[i];
            bus4.in_req_id[i]   = '0;
        end
        for (int i = 0; i < 3; i++) begin
            bus3.in_req_addr[i] = 32'h500 + 32'(i);
            bus3.in_req_id[i]   = '0;
        end
        bus4.in_req_valid  = '0;
        bus4.in_rsp_ready  = 4'b1111;
        bus4.out_req_ready = 1'b0;
        bus4.out_rsp_data  = rsp_line;
        bus4.out_rsp_error = 1'b0;
        bus4.out_rsp_id    = '0;
        bus4.out_rsp_valid = 1'b0;
        bus3.in_req_valid  = '0;
        bus3.in_rsp_ready  = '0;
        bus3.out_req_ready = 1'b0;
        bus3.out_rsp_data  = rsp_line;
        bus3.out_rsp_error = 1'b1;
        bus3.out_rsp_id    = '0;
        bus3.out_rsp_valid = 1'b0;
        #3 rst_ni = 1'b1;

        //  rst vld     pf      rdy rspv rspid   ev  eid     erdy     erspv
        // Reset state, single demand, round-robin pointer moved past the grant.
        add(1, 4'b0000, 4'b0000, 0, 0, 3'b000, 0, 3'b000, 4'b0000, 4'b0000);
        add(0, 4'b0100, 4'b0000, 1, 0, 3'b000, 1, 3'b100, 4'b0100, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b110, 4'b1000, 4'b0000);
        // Demand beats prefetch; prefetch-only round robin.
        add(1, 4'b1001, 4'b0001, 1, 0, 3'b000, 1, 3'b110, 4'b1000, 4'b0000);
        add(0, 4'b0001, 4'b0001, 1, 0, 3'b000, 1, 3'b001, 4'b0001, 4'b0000);
        add(0, 4'b0011, 4'b0011, 1, 0, 3'b000, 1, 3'b011, 4'b0010, 4'b0000);
        // All ports continuously requesting; counters saturate, responses free slots.
        add(1, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b010, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b100, 4'b0100, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b110, 4'b1000, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b010, 4'b0010, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 1, 3'b000, 1, 3'b100, 4'b0100, 4'b0001);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b110, 4'b1000, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 0, 3'b000, 4'b0000, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 1, 3'b010, 0, 3'b000, 4'b0000, 4'b0010);
        add(0, 4'b1111, 4'b0000, 1, 0, 3'b000, 1, 3'b010, 4'b0010, 4'b0000);
        // Grant lock: prefetch on port 1 held against a later demand on port 0.
        add(1, 4'b0010, 4'b0010, 0, 0, 3'b000, 1, 3'b011, 4'b0000, 4'b0000);
        add(0, 4'b0011, 4'b0010, 0, 0, 3'b000, 1, 3'b011, 4'b0000, 4'b0000);
        add(0, 4'b0011, 4'b0010, 0, 0, 3'b000, 1, 3'b011, 4'b0000, 4'b0000);
        add(0, 4'b0011, 4'b0010, 1, 0, 3'b000, 1, 3'b011, 4'b0010, 4'b0000);
        add(0, 4'b0001, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        // Outstanding limit on port 0.
        add(1, 4'b0001, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        add(0, 4'b0001, 4'b0000, 1, 0, 3'b000, 0, 3'b000, 4'b0000, 4'b0000);
        add(0, 4'b0001, 4'b0000, 1, 1, 3'b000, 0, 3'b000, 4'b0000, 4'b0001);
        add(0, 4'b0001, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);
        // Reset while locked drops the lock.
        add(1, 4'b0010, 4'b0000, 0, 0, 3'b000, 1, 3'b010, 4'b0000, 4'b0000);
        add(1, 4'b0011, 4'b0000, 1, 0, 3'b000, 1, 3'b000, 4'b0001, 4'b0000);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(posedge clk_i);
            #1;
            if (v.rst) do_reset();
            bus4.in_req_valid  = v.vld;
            bus4.out_req_ready = v.ordy;
            for (int i = 0; i < 4; i++) bus4.in_req_id[i] = {2'(3 - i), v.pf[i]};
            bus4.out_rsp_valid = v.rsp_v;
            bus4.out_rsp_id    = v.rsp_id;
            #2;
            exp_addr = port_addr[v.exp_id[2:1]];
            ok = (bus4.out_req_valid === v.exp_v) && (bus4.in_req_ready === v.exp_rdy)
                && (bus4.in_rsp_valid === v.exp_rspv) && (bus4.out_rsp_ready === 1'b1)
                && (bad4 === 1'b0);
            if (v.exp_v) begin
                ok = ok && (bus4.out_req_id === v.exp_id) && (bus4.out_req_addr === exp_addr);
            end
            n_vec++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec %0d: got v=%b id=%b addr=%h rdy=%b rspv=%b rsprdy=%b bad=%b; want v=%b id=%b addr=%h rdy=%b rspv=%b rsprdy=1 bad=0",
                         k, bus4.out_req_valid, bus4.out_req_id, bus4.out_req_addr,
                         bus4.in_req_ready, bus4.in_rsp_valid, bus4.out_rsp_ready, bad4,
                         v.exp_v, v.exp_id, exp_addr, v.exp_rdy, v.exp_rspv);
            end
        end

        // Three-port instance: out-of-range response index and routed delivery.
        @(posedge clk_i);
        #1;
        bus4.in_req_valid  = '0;
        bus4.out_rsp_valid = 1'b0;
        do_reset();
        bus3.out_rsp_valid = 1'b1;
        bus3.out_rsp_id    = 3'b110;
        bus3.in_rsp_ready  = 3'b000;
        #2;
        check("bad_rsp_ready", bus3.out_rsp_ready, 1);
        check("bad_rsp_valid", bus3.in_rsp_valid, 0);
        check("bad_pre_edge", bad3, 0);
        @(posedge clk_i);
        #1;
        bus3.out_rsp_valid = 1'b0;
        #2;
        check("bad_set", bad3, 1);
        @(posedge clk_i);
        #1;
        check("bad_hold", bad3, 1);
        bus3.in_req_valid  = 3'b010;
        bus3.in_req_id[1]  = 3'b001;
        bus3.out_req_ready = 1'b1;
        #2;
        check("p1_grant", {bus3.out_req_valid, bus3.out_req_id, bus3.in_req_ready},
              {1'b1, 3'b011, 3'b010});
        check("p1_addr", bus3.out_req_addr, 32'h501);
        @(posedge clk_i);
        #1;
        bus3.in_req_valid  = 3'b000;
        bus3.out_rsp_valid = 1'b1;
        bus3.out_rsp_id    = 3'b011;
        bus3.in_rsp_ready  = 3'b000;
        #2;
        check("rsp_stall", {bus3.in_rsp_valid, bus3.out_rsp_ready}, {3'b010, 1'b0});
        bus3.in_rsp_ready = 3'b010;
        #1;
        check("rsp_p1", {bus3.in_rsp_valid, bus3.out_rsp_ready}, {3'b010, 1'b1});
        check("rsp_bcast_data", bus3.in_rsp_data[2], rsp_line);
        check("rsp_bcast_meta", {bus3.in_rsp_error[0], bus3.in_rsp_id[0]}, {1'b1, 3'b011});
        @(posedge clk_i);
        #1;
        bus3.out_rsp_valid = 1'b0;
        #2;
        check("bad_sticky", bad3, 1);
        check("bad4_clear", bad4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
